uart_pixel_writer: RTL and testbench
====================================

UART_PIXEL_WRITER -- requirements
Module: uart_pixel_writer

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 307200, pixels per frame (640x480); the address wraps after FRAME_PIXELS-1.
REQ-002 SHALL have parameter ADDR_W, default 19, address width; it SHALL satisfy 2^ADDR_W >= FRAME_PIXELS.
REQ-003 clk_uart  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 write_en  output  1  one-cycle RAM write strobe.
REQ-008 write_data  output  12  pixel to write.
REQ-009 addr_wr  output  ADDR_W  RAM write address.
REQ-010 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
REQ-011 sync_err  output  1  one-cycle pulse on a protocol violation.
REQ-012 err_count  output  8  saturating count of protocol violations.

Function
REQ-013 Each byte SHALL be decoded as follows:
- HI byte: bit7=1, bit6=0; bits5:0 = pixel[11:6].
- LO byte: bit7=0, bits5:0 = pixel[5:0]; bit6 is ignored.
- SOF byte: bit7=1, bit6=1; start of frame.
REQ-014 The FSM SHALL have two states, WAIT_H and WAIT_L; the reset state is WAIT_H.
REQ-015 WAIT_H transitions:
- HI: latch bits5:0, go to WAIT_L.
- LO: discard, pulse sync_err, stay in WAIT_H.
- SOF: set the pixel pointer to 0, stay in WAIT_H.
REQ-016 WAIT_L transitions:
- LO: issue a pixel write, go to WAIT_H.
- HI: overwrite the latched high bits, pulse sync_err, stay in WAIT_L.
- SOF: drop the latched high bits, set the pointer to 0, pulse sync_err, go to WAIT_H.
REQ-017 Bytes with rx_valid=0 SHALL be ignored; the FSM SHALL accept rx_valid on consecutive cycles.
REQ-018 A pixel write SHALL assert write_en exactly one cycle, in the cycle after the LO byte's rx_valid.
REQ-019 During that cycle, write_data={latched[5:0], lo[5:0]} and addr_wr=the pointer value before increment.
REQ-020 After each write, the pointer SHALL increment by 1, wrapping from FRAME_PIXELS-1 to 0.
REQ-021 frame_done SHALL pulse in the same cycle as the write to address FRAME_PIXELS-1.
REQ-022 All outputs SHALL be registered; with no write in progress, write_en=0 and write_data/addr_wr hold their last values.
REQ-023 sync_err SHALL pulse in the cycle after the offending byte's rx_valid.

Reset
REQ-024 While rst_n=0: state=WAIT_H, pointer=0, latched bits=0.
REQ-025 While rst_n=0: write_en=0, write_data=0, addr_wr=0, frame_done=0, sync_err=0, err_count=0.
REQ-026 Reset asserted mid-pixel (in WAIT_L) SHALL discard the partial pixel and SHALL issue no write.

Configuration
REQ-027 With macro PIXEL_WR_ERRCNT_EN defined, err_count SHALL increment on every sync_err pulse and saturate at 255.
REQ-028 Without PIXEL_WR_ERRCNT_EN, err_count SHALL be constant 0 and no counter logic SHALL be built; sync_err is unaffected.

Verification
REQ-029 Reset, then bytes 0x80, 0x15 -> one cycle later write_en=1, write_data=0x015, addr_wr=0.
REQ-030 Pixel pairs streamed back-to-back on consecutive cycles, pixels 0xABC, 0x123 (0xAA,0x3C,0x84,0x23) -> writes at addr 0 and 1, data 0xABC then 0x123.
REQ-031 FRAME_PIXELS=4, five pixels sent -> addresses 0,1,2,3,0; frame_done high only with addr_wr=3.
REQ-032 Error recovery:
- 0x05 in WAIT_H -> sync_err pulse, no write.
- 0x81, 0x82, 0x03 -> one sync_err pulse, then write_data=0x083.
- err_count=2 if PIXEL_WR_ERRCNT_EN is defined, else 0.
REQ-033 Three pixels sent, then 0xC0, then one pixel -> that pixel is written at addr_wr=0.
REQ-034 rst_n pulsed low between a HI byte and its LO byte -> no write_en; the next full pair is written at addr 0.

Source files
------------

// File: rtl/uart_pixel_writer_if.sv
// Byte-in / pixel-write-out signal bundle for uart_pixel_writer.
// slave is the writer's view; master is the byte source / RAM side.
interface uart_pixel_writer_if #(
  parameter int ADDR_W = 19
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              write_en;
  logic [11:0]       write_data;
  logic [ADDR_W-1:0] addr_wr;
  logic              frame_done;
  logic              sync_err;
  logic [7:0]        err_count;

  modport master (
    output rx_valid, rx_data,
    input  write_en, write_data, addr_wr, frame_done, sync_err, err_count
  );

  modport slave (
    input  rx_valid, rx_data,
    output write_en, write_data, addr_wr, frame_done, sync_err, err_count
  );
endinterface

// File: rtl/uart_pixel_writer.sv
// Assembles 12-bit pixels from HI/LO UART byte pairs and writes them to frame RAM.
// Optional saturating protocol-error counter enabled by macro PIXEL_WR_ERRCNT_EN.
module uart_pixel_writer #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19
) (
  input  logic                clk_uart,
  input  logic                rst_n,
  uart_pixel_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  typedef enum logic {
    WAIT_H = 1'b0,
    WAIT_L = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [5:0]        hi_reg, hi_next;
  logic              write_en_reg, write_en_next;
  logic [11:0]       write_data_reg, write_data_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              frame_done_reg, frame_done_next;
  logic              sync_err_reg, sync_err_next;

  logic byte_hi, byte_lo, byte_sof;

  // bit6 is a don't-care on LO bytes
  assign byte_lo  = bus.rx_valid & ~bus.rx_data[7];
  assign byte_hi  = bus.rx_valid &  bus.rx_data[7] & ~bus.rx_data[6];
  assign byte_sof = bus.rx_valid &  bus.rx_data[7] &  bus.rx_data[6];

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= WAIT_H;
      ptr_reg        <= '0;
      hi_reg         <= '0;
      write_en_reg   <= 1'b0;
      write_data_reg <= '0;
      addr_reg       <= '0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      hi_reg         <= hi_next;
      write_en_reg   <= write_en_next;
      write_data_reg <= write_data_next;
      addr_reg       <= addr_next;
      frame_done_reg <= frame_done_next;
      sync_err_reg   <= sync_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    hi_next         = hi_reg;
    write_en_next   = 1'b0;
    write_data_next = write_data_reg;
    addr_next       = addr_reg;
    frame_done_next = 1'b0;
    sync_err_next   = 1'b0;

    unique case (state_reg)
      WAIT_H: begin
        if (byte_hi) begin
          hi_next    = bus.rx_data[5:0];
          state_next = WAIT_L;
        end else if (byte_lo) begin
          sync_err_next = 1'b1;
        end else if (byte_sof) begin
          ptr_next = '0;
        end
      end
      WAIT_L: begin
        if (byte_lo) begin
          write_en_next   = 1'b1;
          write_data_next = {hi_reg, bus.rx_data[5:0]};
          addr_next       = ptr_reg;
          frame_done_next = (ptr_reg == LAST_ADDR);
          ptr_next        = (ptr_reg == LAST_ADDR) ? '0 : ptr_reg + ADDR_W'(1);
          state_next      = WAIT_H;
        end else if (byte_hi) begin
          hi_next       = bus.rx_data[5:0];
          sync_err_next = 1'b1;
        end else if (byte_sof) begin
          hi_next       = '0;
          ptr_next      = '0;
          sync_err_next = 1'b1;
          state_next    = WAIT_H;
        end
      end
      default: state_next = WAIT_H;
    endcase
  end

`ifdef PIXEL_WR_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk_uart or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (sync_err_next && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_reg;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.write_en   = write_en_reg;
  assign bus.write_data = write_data_reg;
  assign bus.addr_wr    = addr_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.sync_err   = sync_err_reg;

endmodule

// File: tb/tb_uart_pixel_writer.sv
// Scoreboard bench for uart_pixel_writer with a 4-pixel frame; stimulus queues
// expected write/error events, a negedge monitor pops and compares them.
module tb_uart_pixel_writer;

  localparam int FP = 4;
  localparam int AW = 3;

`ifdef PIXEL_WR_ERRCNT_EN
  localparam int EXP_ERRCNT = 2;
`else
  localparam int EXP_ERRCNT = 0;
`endif

  typedef struct {
    bit          is_err;
    logic [11:0] data;
    logic [AW-1:0] addr;
    bit          fd;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  uart_pixel_writer_if #(.ADDR_W(AW)) bus ();

  uart_pixel_writer #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .clk_uart (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
    end
  endtask

  task automatic exp_write(input logic [11:0] d, input int a);
    ev_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.addr   = AW'(a);
    e.fd     = (a == FP - 1);
    exp_q.push_back(e);
  endtask

  task automatic exp_error();
    ev_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    e.addr   = '0;
    e.fd     = 1'b0;
    exp_q.push_back(e);
  endtask

  // Sends a pixel as a HI/LO pair; lo_b6 exercises the ignored LO bit6.
  task automatic pixel(input logic [11:0] p, input int a, input bit lo_b6);
    exp_write(p, a);
    send({2'b10, p[11:6]});
    send({1'b0, lo_b6, p[5:0]});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write_en"},   int'(bus.write_en),   0);
    chk({tag, "_write_data"}, int'(bus.write_data), 0);
    chk({tag, "_addr_wr"},    int'(bus.addr_wr),    0);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    chk({tag, "_sync_err"},   int'(bus.sync_err),   0);
    chk({tag, "_err_count"},  int'(bus.err_count),  0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_en || bus.sync_err) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: write_en=%0b sync_err=%0b data=0x%0h addr=%0d, expected none",
                   bus.write_en, bus.sync_err, bus.write_data, bus.addr_wr);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("ev_write_en", int'(bus.write_en), int'(!e.is_err));
          chk("ev_sync_err", int'(bus.sync_err), int'(e.is_err));
          if (!e.is_err) begin
            chk("ev_write_data", int'(bus.write_data), int'(e.data));
            chk("ev_addr_wr",    int'(bus.addr_wr),    int'(e.addr));
            chk("ev_frame_done", int'(bus.frame_done), int'(e.fd));
            $display("write data=0x%03h addr=%0d frame_done=%0b", bus.write_data, bus.addr_wr, bus.frame_done);
          end else begin
            $display("sync_err pulse, err_count=%0d", bus.err_count);
          end
        end
      end
      if (bus.frame_done && !bus.write_en) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_done_alone: frame_done=1 write_en=0, required write_en=1");
      end
    end
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic pixel: 0x80, 0x15 -> 0x015 at addr 0
    pixel(12'h015, 0, 1'b0);
    idle(2);
    chk("hold_write_en",   int'(bus.write_en),   0);
    chk("hold_write_data", int'(bus.write_data), 'h015);
    chk("hold_addr_wr",    int'(bus.addr_wr),    0);

    // Back-to-back pairs after SOF: 0xAA,0x3C,0x84,0x23
    send(8'hC0);
    exp_write(12'hABC, 0);
    send(8'hAA);
    send(8'h3C);
    exp_write(12'h123, 1);
    send(8'h84);
    send(8'h23);
    idle(2);

    // Frame wrap: five pixels -> addr 0,1,2,3,0
    send(8'hC0);
    pixel(12'h001, 0, 1'b1);
    pixel(12'hFFF, 1, 1'b0);
    pixel(12'h5A5, 2, 1'b1);
    pixel(12'h7C3, 3, 1'b0);
    pixel(12'h800, 0, 1'b1);
    idle(2);

    // Error recovery, from a fresh reset so err_count starts at 0
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset2");
    idle(1);
    rst_n = 1'b1;
    exp_error();
    send(8'h05);
    exp_error();
    exp_write(12'h083, 0);
    send(8'h81);
    send(8'h82);
    send(8'h03);
    idle(2);
    chk("err_count", int'(bus.err_count), EXP_ERRCNT);

    // SOF in WAIT_L drops the partial pixel and rewinds the pointer
    send(8'h90);
    exp_error();
    send(8'hC0);
    pixel(12'h2C4, 0, 1'b0);
    idle(2);

    // Three pixels, SOF, one pixel -> rewound to addr 0
    pixel(12'h111, 1, 1'b0);
    pixel(12'h222, 2, 1'b0);
    pixel(12'h333, 3, 1'b0);
    send(8'hC0);
    pixel(12'h444, 0, 1'b1);
    idle(2);

    // Reset between HI and LO: no write, next pair lands at addr 0
    send(8'h80);
    idle(1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset3");
    send(8'h15);
    idle(1);
    chk("reset_no_write", int'(bus.write_en), 0);
    rst_n = 1'b1;
    exp_write(12'h3E1, 0);
    send(8'h8F);
    send(8'h21);
    idle(2);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
